// File: rtl/hog_bridge_ctrl_pkg.sv
// Shared register map, control/status bit positions and bridge FSM state encoding.
// Pure declarations; no latency or flow control of its own.
package hog_bridge_ctrl_pkg;

   localparam int ADDR_W = 5;

   localparam logic [ADDR_W-1:0] ADDR_CTRL     = 5'd0;
   localparam logic [ADDR_W-1:0] ADDR_STATUS   = 5'd1;
   localparam logic [ADDR_W-1:0] ADDR_IRQ_CLR  = 5'd2;
   localparam logic [ADDR_W-1:0] ADDR_IMG_SIZE = 5'd3;
   localparam logic [ADDR_W-1:0] ADDR_PIX_PORT = 5'd4;
   localparam logic [ADDR_W-1:0] ADDR_RES_PORT = 5'd5;

   localparam int CTRL_START_BIT  = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;

   localparam int STAT_BUSY_BIT = 0;
   localparam int STAT_DONE_BIT = 1;
   localparam int STAT_ERR_BIT  = 2;

   localparam int CLR_DONE_BIT = 0;
   localparam int CLR_ERR_BIT  = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_WAIT_PUSH,
      ST_WAIT_POP,
      ST_ACK,
      ST_HOLD
   } state_t;

   function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                               input logic [31:0] upd,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = cur;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = upd[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/hog_bridge_ctrl.sv
// Register bridge for the HOG core: control/status regs plus pixel push and result pop ports.
// Register access acks two cycles after bus_enable; stream accesses wait on valid/ready up to TIMEOUT cycles.
module hog_bridge_ctrl
   import hog_bridge_ctrl_pkg::*;
#(
   parameter int DATA_W  = 128,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [4:0]        bridge_address,
   input  logic              bridge_bus_enable,
   input  logic [15:0]       bridge_byte_enable,
   input  logic              bridge_rw,
   input  logic [DATA_W-1:0] bridge_write_data,
   output logic [DATA_W-1:0] bridge_read_data,
   output logic              bridge_acknowledge,
   output logic              bridge_irq,
   output logic [15:0]       cfg_img_w,
   output logic [15:0]       cfg_img_h,
   output logic              core_start,
   input  logic              core_busy,
   input  logic              core_done,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   input  logic [DATA_W-1:0] res_data,
   input  logic              res_valid,
   output logic              res_ready
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   state_t            state;
   logic [4:0]        addr_q;
   logic              rw_q;
   logic [15:0]       be_q;
   logic [DATA_W-1:0] wdata_q;
   logic [TW-1:0]     timer;

   logic              irq_en;
   logic              done_flag;
   logic              err_flag;
   logic [15:0]       img_w;
   logic [15:0]       img_h;

   logic              reg_wr;
   logic              start_req;
   logic              clr_done;
   logic              clr_err;
   logic              pix_be_err;
   logic              wait_timeout;
   logic              err_set;
   logic [31:0]       img_size_new;
   logic [DATA_W-1:0] rd_mux;

   assign reg_wr       = (state == ST_ACCESS) && !rw_q;
   assign start_req    = reg_wr && (addr_q == ADDR_CTRL) && be_q[0] && wdata_q[CTRL_START_BIT];
   assign clr_done     = reg_wr && (addr_q == ADDR_IRQ_CLR) && be_q[0] && wdata_q[CLR_DONE_BIT];
   assign clr_err      = reg_wr && (addr_q == ADDR_IRQ_CLR) && be_q[0] && wdata_q[CLR_ERR_BIT];
   assign pix_be_err   = reg_wr && (addr_q == ADDR_PIX_PORT) && !(&be_q);
   assign wait_timeout = ((state == ST_WAIT_PUSH && !pix_ready) ||
                          (state == ST_WAIT_POP  && !res_valid)) && (timer == TIMER_LAST);
   assign err_set      = (start_req && core_busy) || pix_be_err || wait_timeout;
   assign img_size_new = merge_bytes({img_h, img_w}, wdata_q[31:0], be_q[3:0]);

   assign pix_data  = wdata_q;
   assign cfg_img_w = img_w;
   assign cfg_img_h = img_h;

   always_comb begin
      rd_mux = '0;
      case (addr_q)
         ADDR_CTRL:     rd_mux[CTRL_IRQ_EN_BIT] = irq_en;
         ADDR_STATUS: begin
            rd_mux[STAT_BUSY_BIT] = core_busy;
            rd_mux[STAT_DONE_BIT] = done_flag;
            rd_mux[STAT_ERR_BIT]  = err_flag;
         end
         ADDR_IMG_SIZE: rd_mux[31:0] = {img_h, img_w};
         default:       rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state              <= ST_IDLE;
         addr_q             <= '0;
         rw_q               <= 1'b0;
         be_q               <= '0;
         wdata_q            <= '0;
         timer              <= '0;
         bridge_acknowledge <= 1'b0;
         bridge_read_data   <= '0;
         pix_valid          <= 1'b0;
         res_ready          <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bridge_bus_enable) begin
                  addr_q  <= bridge_address;
                  rw_q    <= bridge_rw;
                  be_q    <= bridge_byte_enable;
                  wdata_q <= bridge_write_data;
                  state   <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               timer <= '0;
               if (!rw_q && addr_q == ADDR_PIX_PORT) begin
                  // a partial-lane pixel write is rejected but still completes on the bus
                  if (&be_q) begin
                     pix_valid <= 1'b1;
                     state     <= ST_WAIT_PUSH;
                  end else begin
                     bridge_acknowledge <= 1'b1;
                     state              <= ST_ACK;
                  end
               end else if (rw_q && addr_q == ADDR_RES_PORT) begin
                  res_ready <= 1'b1;
                  state     <= ST_WAIT_POP;
               end else begin
                  if (rw_q) bridge_read_data <= rd_mux;
                  bridge_acknowledge <= 1'b1;
                  state              <= ST_ACK;
               end
            end
            ST_WAIT_PUSH: begin
               if (pix_ready) begin
                  pix_valid          <= 1'b0;
                  bridge_acknowledge <= 1'b1;
                  state              <= ST_ACK;
               end else if (wait_timeout) begin
                  pix_valid          <= 1'b0;
                  bridge_read_data   <= '0;
                  bridge_acknowledge <= 1'b1;
                  state              <= ST_ACK;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            ST_WAIT_POP: begin
               if (res_valid) begin
                  res_ready          <= 1'b0;
                  bridge_read_data   <= res_data;
                  bridge_acknowledge <= 1'b1;
                  state              <= ST_ACK;
               end else if (wait_timeout) begin
                  res_ready          <= 1'b0;
                  bridge_read_data   <= '0;
                  bridge_acknowledge <= 1'b1;
                  state              <= ST_ACK;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            ST_ACK: begin
               bridge_acknowledge <= 1'b0;
               state              <= ST_HOLD;
            end
            ST_HOLD: begin
               if (!bridge_bus_enable) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         irq_en     <= 1'b0;
         img_w      <= '0;
         img_h      <= '0;
         done_flag  <= 1'b0;
         err_flag   <= 1'b0;
         core_start <= 1'b0;
         bridge_irq <= 1'b0;
      end else begin
         core_start <= start_req && !core_busy;
         if (reg_wr && addr_q == ADDR_CTRL && be_q[0]) irq_en <= wdata_q[CTRL_IRQ_EN_BIT];
         if (reg_wr && addr_q == ADDR_IMG_SIZE) {img_h, img_w} <= img_size_new;
         // set has priority over a clear landing in the same cycle
         done_flag  <= core_done | (done_flag & ~clr_done);
         err_flag   <= err_set | (err_flag & ~clr_err);
         bridge_irq <= irq_en & done_flag;
      end
   end

endmodule

// File: tb/tb_hog_bridge_ctrl.sv
// Self-checking bench for hog_bridge_ctrl against a register-level reference model.
module tb_hog_bridge_ctrl;
   import hog_bridge_ctrl_pkg::*;

   localparam int DW = 128;
   localparam int TO = 15;

   logic          clk_clk = 1'b0;
   logic          reset_reset_n = 1'b1;
   logic [4:0]    bridge_address = '0;
   logic          bridge_bus_enable = 1'b0;
   logic [15:0]   bridge_byte_enable = '0;
   logic          bridge_rw = 1'b0;
   logic [DW-1:0] bridge_write_data = '0;
   logic [DW-1:0] bridge_read_data;
   logic          bridge_acknowledge;
   logic          bridge_irq;
   logic [15:0]   cfg_img_w;
   logic [15:0]   cfg_img_h;
   logic          core_start;
   logic          core_busy = 1'b0;
   logic          core_done = 1'b0;
   logic [DW-1:0] pix_data;
   logic          pix_valid;
   logic          pix_ready = 1'b0;
   logic [DW-1:0] res_data = '0;
   logic          res_valid = 1'b0;
   logic          res_ready;

   hog_bridge_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .bridge_address(bridge_address), .bridge_bus_enable(bridge_bus_enable),
      .bridge_byte_enable(bridge_byte_enable), .bridge_rw(bridge_rw),
      .bridge_write_data(bridge_write_data), .bridge_read_data(bridge_read_data),
      .bridge_acknowledge(bridge_acknowledge), .bridge_irq(bridge_irq),
      .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h),
      .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
   );

   always #5 clk_clk = ~clk_clk;

   int n_tests = 0;
   int n_fail  = 0;
   int start_cnt = 0;
   logic [DW-1:0] push_q[$];

   // reference model: architectural register contents
   logic        m_irq_en = 1'b0;
   logic [31:0] m_img    = '0;
   logic        m_done   = 1'b0;
   logic        m_err    = 1'b0;

   always @(posedge clk_clk) begin
      if (pix_valid && pix_ready) push_q.push_back(pix_data);
      if (core_start) start_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic bus_xfer(input logic [4:0] a, input logic rw, input logic [15:0] be,
                           input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                           output int lat, output logic ack_after);
      bridge_address     = a;
      bridge_rw          = rw;
      bridge_byte_enable = be;
      bridge_write_data  = wd;
      bridge_bus_enable  = 1'b1;
      lat = 0;
      do begin
         step();
         lat++;
      end while (!bridge_acknowledge && lat < 100);
      if (!bridge_acknowledge) begin
         n_tests++; n_fail++;
         $display("FAIL bus_ack_missing addr=%0d got=0 exp=1", a);
      end
      rd = bridge_read_data;
      bridge_bus_enable = 1'b0;
      step();
      ack_after = bridge_acknowledge;
      step();
   endtask

   function automatic logic [DW-1:0] status_exp();
      logic [DW-1:0] v;
      v = '0;
      v[2:0] = {m_err, m_done, core_busy};
      return v;
   endfunction

   task automatic test_reset();
      logic [DW-1:0] obs[9];
      string nm[9];
      #2 reset_reset_n = 1'b0;
      #1;
      obs[0] = DW'(bridge_acknowledge); nm[0] = "rst_ack";
      obs[1] = DW'(bridge_irq);         nm[1] = "rst_irq";
      obs[2] = DW'(pix_valid);          nm[2] = "rst_pix_valid";
      obs[3] = DW'(res_ready);          nm[3] = "rst_res_ready";
      obs[4] = DW'(core_start);         nm[4] = "rst_core_start";
      obs[5] = bridge_read_data;        nm[5] = "rst_read_data";
      obs[6] = DW'(cfg_img_w);          nm[6] = "rst_img_w";
      obs[7] = DW'(cfg_img_h);          nm[7] = "rst_img_h";
      obs[8] = pix_data;                nm[8] = "rst_pix_data";
      for (int i = 0; i < 9; i++) begin
         n_tests++;
         if (obs[i] !== '0) begin
            n_fail++;
            $display("FAIL %s got=%h exp=0", nm[i], obs[i]);
         end
      end
      repeat (3) @(posedge clk_clk);
      #1 reset_reset_n = 1'b1;
      step();
   endtask

   task automatic test_reg_rw();
      logic [DW-1:0] rd;
      int lat;
      logic aa;
      bus_xfer(ADDR_CTRL, 1'b0, 16'hFFFF, DW'(32'h2), rd, lat, aa);
      m_irq_en = 1'b1;
      n_tests++;
      if (lat !== 2) begin n_fail++; $display("FAIL reg_wr_latency got=%0d exp=2", lat); end
      n_tests++;
      if (aa !== 1'b0) begin n_fail++; $display("FAIL ack_single_pulse got=%b exp=0", aa); end
      bus_xfer(ADDR_IMG_SIZE, 1'b0, 16'hFFFF, DW'(32'h00F0_0140), rd, lat, aa);
      m_img = 32'h00F0_0140;
      bus_xfer(ADDR_CTRL, 1'b1, 16'hFFFF, '0, rd, lat, aa);
      n_tests++;
      if (rd !== DW'(32'h2)) begin n_fail++; $display("FAIL ctrl_readback got=%h exp=2", rd); end
      n_tests++;
      if (lat !== 2) begin n_fail++; $display("FAIL reg_rd_latency got=%0d exp=2", lat); end
      bus_xfer(ADDR_IMG_SIZE, 1'b1, 16'hFFFF, '0, rd, lat, aa);
      n_tests++;
      if (rd !== DW'(32'h00F0_0140)) begin n_fail++; $display("FAIL img_readback got=%h exp=00f00140", rd); end
      n_tests++;
      if (cfg_img_w !== 16'd320 || cfg_img_h !== 16'd240) begin
         n_fail++;
         $display("FAIL cfg_img got=%0d x %0d exp=320 x 240", cfg_img_w, cfg_img_h);
      end
   endtask

   task automatic test_byte_enable();
      logic [DW-1:0] rd, wd;
      logic [15:0] be;
      logic [4:0] a;
      int lat;
      logic aa;
      for (int it = 0; it < 8; it++) begin
         be = 16'($urandom);
         wd = {$urandom, $urandom, $urandom, $urandom};
         bus_xfer(ADDR_IMG_SIZE, 1'b0, be, wd, rd, lat, aa);
         for (int b = 0; b < 4; b++) if (be[b]) m_img[8*b +: 8] = wd[8*b +: 8];
         bus_xfer(ADDR_IMG_SIZE, 1'b1, 16'hFFFF, '0, rd, lat, aa);
         n_tests++;
         if (rd !== DW'(m_img)) begin n_fail++; $display("FAIL img_be it=%0d got=%h exp=%h", it, rd, m_img); end
         n_tests++;
         if ({cfg_img_h, cfg_img_w} !== m_img) begin
            n_fail++;
            $display("FAIL cfg_be it=%0d got=%h exp=%h", it, {cfg_img_h, cfg_img_w}, m_img);
         end
         a = 5'($urandom_range(6, 31));
         bus_xfer(a, 1'b0, 16'hFFFF, wd, rd, lat, aa);
         bus_xfer(a, 1'b1, 16'hFFFF, '0, rd, lat, aa);
         n_tests++;
         if (rd !== '0) begin n_fail++; $display("FAIL unmapped_read addr=%0d got=%h exp=0", a, rd); end
      end
      bus_xfer(ADDR_CTRL, 1'b0, 16'hFFFE, DW'(32'h0), rd, lat, aa);
      bus_xfer(ADDR_CTRL, 1'b1, 16'hFFFF, '0, rd, lat, aa);
      n_tests++;
      if (rd !== DW'({m_irq_en, 1'b0})) begin n_fail++; $display("FAIL ctrl_be_masked got=%h exp=%h", rd, {m_irq_en, 1'b0}); end
      bus_xfer(ADDR_PIX_PORT, 1'b1, 16'hFFFF, '0, rd, lat, aa);
      n_tests++;
      if (rd !== '0) begin n_fail++; $display("FAIL pix_port_read got=%h exp=0", rd); end
   endtask

   task automatic test_pix_push();
      logic [DW-1:0] data, rd;
      int stall, vcyc, w, lat;
      logic ok, aa;
      for (int it = 0; it < 4; it++) begin
         stall = (it == 0) ? 5 : $urandom_range(0, 6);
         data  = {$urandom, $urandom, $urandom, $urandom};
         bridge_address = ADDR_PIX_PORT; bridge_rw = 1'b0;
         bridge_byte_enable = 16'hFFFF; bridge_write_data = data;
         bridge_bus_enable = 1'b1; pix_ready = 1'b0;
         w = 0;
         do begin step(); w++; end while (!pix_valid && w < 20);
         vcyc = 0; ok = 1'b1;
         repeat (stall) begin
            if (pix_valid) vcyc++;
            if (pix_data !== data || bridge_acknowledge) ok = 1'b0;
            step();
         end
         pix_ready = 1'b1;
         if (pix_valid) vcyc++;
         if (pix_data !== data || bridge_acknowledge) ok = 1'b0;
         step();
         pix_ready = 1'b0;
         n_tests++;
         if (vcyc !== stall + 1) begin n_fail++; $display("FAIL pix_valid_hold it=%0d got=%0d exp=%0d", it, vcyc, stall + 1); end
         n_tests++;
         if (!ok) begin n_fail++; $display("FAIL pix_data_stable it=%0d got=unstable exp=stable", it); end
         n_tests++;
         if (bridge_acknowledge !== 1'b1 || pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pix_ack_after_hs it=%0d got=ack%b/valid%b exp=ack1/valid0", it, bridge_acknowledge, pix_valid);
         end
         bridge_bus_enable = 1'b0;
         step(); step();
         n_tests++;
         if (push_q.size() != 1 || push_q[0] !== data) begin
            n_fail++;
            $display("FAIL pix_pushed it=%0d got=%0d words exp=1 word %h", it, push_q.size(), data);
         end
         push_q.delete();
      end
      bus_xfer(ADDR_PIX_PORT, 1'b0, 16'h7FFF, '1, rd, lat, aa);
      m_err = 1'b1;
      n_tests++;
      if (push_q.size() != 0) begin n_fail++; $display("FAIL pix_bad_be_push got=%0d exp=0", push_q.size()); end
      bus_xfer(ADDR_STATUS, 1'b1, 16'hFFFF, '0, rd, lat, aa);
      n_tests++;
      if (rd !== status_exp()) begin n_fail++; $display("FAIL pix_bad_be_status got=%h exp=%h", rd, status_exp()); end
      bus_xfer(ADDR_IRQ_CLR, 1'b0, 16'hFFFF, DW'(32'h2), rd, lat, aa);
      m_err = 1'b0;
      bus_xfer(ADDR_STATUS, 1'b1, 16'hFFFF, '0, rd, lat, aa);
      n_tests++;
      if (rd !== status_exp()) begin n_fail++; $display("FAIL err_clear_status got=%h exp=%h", rd, status_exp()); end
   endtask

   task automatic test_res_pop();
      logic [DW-1:0] data, rd;
      int d, w, rr, lat;
      logic aa;
      for (int it = 0; it < 3; it++) begin
         d = $urandom_range(0, 5);
         data = {$urandom, $urandom, $urandom, $urandom};
         bridge_address = ADDR_RES_PORT; bridge_rw = 1'b1;
         bridge_byte_enable = 16'hFFFF; bridge_bus_enable = 1'b1;
         w = 0;
         do begin step(); w++; end while (!res_ready && w < 20);
         repeat (d) step();
         res_valid = 1'b1; res_data = data;
         step();
         res_valid = 1'b0; res_data = '0;
         n_tests++;
         if (bridge_acknowledge !== 1'b1 || bridge_read_data !== data || res_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL res_pop it=%0d got=ack%b %h exp=ack1 %h", it, bridge_acknowledge, bridge_read_data, data);
         end
         bridge_bus_enable = 1'b0;
         step(); step(); step();
         n_tests++;
         if (bridge_read_data !== data) begin n_fail++; $display("FAIL res_data_held it=%0d got=%h exp=%h", it, bridge_read_data, data); end
      end
      bridge_address = ADDR_RES_PORT; bridge_rw = 1'b1; bridge_bus_enable = 1'b1;
      rr = 0; lat = 0;
      do begin
         step(); lat++;
         if (res_ready) rr++;
      end while (!bridge_acknowledge && lat < 100);
      m_err = 1'b1;
      n_tests++;
      if (rr !== TO || bridge_acknowledge !== 1'b1) begin
         n_fail++;
         $display("FAIL res_timeout_wait got=%0d cycles ack%b exp=%0d cycles ack1", rr, bridge_acknowledge, TO);
      end
      n_tests++;
      if (bridge_read_data !== '0) begin n_fail++; $display("FAIL res_timeout_data got=%h exp=0", bridge_read_data); end
      bridge_bus_enable = 1'b0;
      step(); step();
      bus_xfer(ADDR_STATUS, 1'b1, 16'hFFFF, '0, rd, lat, aa);
      n_tests++;
      if (rd[2] !== 1'b1 || rd !== status_exp()) begin n_fail++; $display("FAIL res_timeout_status got=%h exp=%h", rd, status_exp()); end
      bus_xfer(ADDR_IRQ_CLR, 1'b0, 16'hFFFF, DW'(32'h2), rd, lat, aa);
      m_err = 1'b0;
   endtask

   task automatic test_irq();
      logic [DW-1:0] rd;
      int lat;
      logic aa;
      bus_xfer(ADDR_CTRL, 1'b0, 16'hFFFF, DW'(32'h2), rd, lat, aa);
      m_irq_en = 1'b1;
      bus_xfer(ADDR_IRQ_CLR, 1'b0, 16'hFFFF, DW'(32'h1), rd, lat, aa);
      m_done = 1'b0;
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      m_done = 1'b1;
      n_tests++;
      if (bridge_irq !== 1'b0) begin n_fail++; $display("FAIL irq_delay got=%b exp=0", bridge_irq); end
      step();
      n_tests++;
      if (bridge_irq !== (m_irq_en & m_done)) begin n_fail++; $display("FAIL irq_set got=%b exp=1", bridge_irq); end
      // clear landing in the same cycle as a new done pulse
      bridge_address = ADDR_IRQ_CLR; bridge_rw = 1'b0;
      bridge_byte_enable = 16'hFFFF; bridge_write_data = DW'(32'h1);
      bridge_bus_enable = 1'b1;
      step();
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      bridge_bus_enable = 1'b0;
      n_tests++;
      if (bridge_irq !== 1'b1) begin n_fail++; $display("FAIL irq_concurrent_a got=%b exp=1", bridge_irq); end
      step(); step();
      n_tests++;
      if (bridge_irq !== 1'b1) begin n_fail++; $display("FAIL irq_concurrent_b got=%b exp=1", bridge_irq); end
      bus_xfer(ADDR_STATUS, 1'b1, 16'hFFFF, '0, rd, lat, aa);
      n_tests++;
      if (rd !== status_exp()) begin n_fail++; $display("FAIL done_concurrent_status got=%h exp=%h", rd, status_exp()); end
      bus_xfer(ADDR_IRQ_CLR, 1'b0, 16'hFFFF, DW'(32'h1), rd, lat, aa);
      m_done = 1'b0;
      n_tests++;
      if (bridge_irq !== 1'b0) begin n_fail++; $display("FAIL irq_cleared got=%b exp=0", bridge_irq); end
      bus_xfer(ADDR_CTRL, 1'b0, 16'hFFFF, DW'(32'h0), rd, lat, aa);
      m_irq_en = 1'b0;
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      m_done = 1'b1;
      step(); step();
      n_tests++;
      if (bridge_irq !== (m_irq_en & m_done)) begin n_fail++; $display("FAIL irq_masked got=%b exp=0", bridge_irq); end
      bus_xfer(ADDR_IRQ_CLR, 1'b0, 16'hFFFF, DW'(32'h1), rd, lat, aa);
      m_done = 1'b0;
   endtask

   task automatic test_start();
      logic [DW-1:0] rd;
      int lat, s0;
      logic aa;
      core_busy = 1'b0;
      s0 = start_cnt;
      bus_xfer(ADDR_CTRL, 1'b0, 16'hFFFF, DW'(32'h3), rd, lat, aa);
      m_irq_en = 1'b1;
      step(); step();
      n_tests++;
      if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL start_pulse got=%0d exp=1", start_cnt - s0); end
      bus_xfer(ADDR_CTRL, 1'b1, 16'hFFFF, '0, rd, lat, aa);
      n_tests++;
      if (rd !== DW'({m_irq_en, 1'b0})) begin n_fail++; $display("FAIL start_self_clear got=%h exp=%h", rd, {m_irq_en, 1'b0}); end
      core_busy = 1'b1;
      s0 = start_cnt;
      bus_xfer(ADDR_CTRL, 1'b0, 16'hFFFF, DW'(32'h1), rd, lat, aa);
      m_irq_en = 1'b0;
      m_err = 1'b1;
      step(); step();
      n_tests++;
      if (start_cnt - s0 !== 0) begin n_fail++; $display("FAIL start_while_busy got=%0d exp=0", start_cnt - s0); end
      bus_xfer(ADDR_STATUS, 1'b1, 16'hFFFF, '0, rd, lat, aa);
      n_tests++;
      if (rd !== status_exp()) begin n_fail++; $display("FAIL busy_status got=%h exp=%h", rd, status_exp()); end
      core_busy = 1'b0;
      bus_xfer(ADDR_IRQ_CLR, 1'b0, 16'hFFFF, DW'(32'h2), rd, lat, aa);
      m_err = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] rd;
      int lat, w;
      logic aa;
      bus_xfer(ADDR_IMG_SIZE, 1'b0, 16'hFFFF, DW'($urandom | 32'h1), rd, lat, aa);
      push_q.delete();
      bridge_address = ADDR_PIX_PORT; bridge_rw = 1'b0;
      bridge_byte_enable = 16'hFFFF; bridge_write_data = {$urandom, $urandom, $urandom, $urandom};
      bridge_bus_enable = 1'b1; pix_ready = 1'b0;
      w = 0;
      do begin step(); w++; end while (!pix_valid && w < 20);
      step();
      #2 reset_reset_n = 1'b0;
      #1;
      m_irq_en = 1'b0; m_img = '0; m_done = 1'b0; m_err = 1'b0;
      n_tests++;
      if (pix_valid !== 1'b0 || bridge_acknowledge !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_abort got=valid%b/ack%b exp=valid0/ack0", pix_valid, bridge_acknowledge);
      end
      n_tests++;
      if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, ST_IDLE); end
      n_tests++;
      if ({cfg_img_h, cfg_img_w} !== m_img) begin n_fail++; $display("FAIL reset_cfg got=%h exp=%h", {cfg_img_h, cfg_img_w}, m_img); end
      bridge_address = ADDR_CTRL; bridge_rw = 1'b1;
      step();
      reset_reset_n = 1'b1;
      lat = 0;
      do begin step(); lat++; end while (!bridge_acknowledge && lat < 20);
      n_tests++;
      if (lat !== 2 || bridge_acknowledge !== 1'b1) begin n_fail++; $display("FAIL post_reset_access got=%0d cycles exp=2", lat); end
      n_tests++;
      if (bridge_read_data !== DW'({m_irq_en, 1'b0})) begin n_fail++; $display("FAIL post_reset_ctrl got=%h exp=0", bridge_read_data); end
      bridge_bus_enable = 1'b0;
      step(); step();
      n_tests++;
      if (push_q.size() != 0) begin n_fail++; $display("FAIL aborted_push got=%0d exp=0", push_q.size()); end
   endtask

   initial begin
      test_reset();
      test_reg_rw();
      test_byte_enable();
      test_pix_push();
      test_res_pop();
      test_irq();
      test_start();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
